term_link: RTL and testbench

//  Design-side endpoint of the simulator byte link (txdata/txclk/txready, rxdata/rxclk/rxready).

---
 rtl/term_link.sv | 159 +++++++++++++++
 tb/tb_term_link.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/term_link.sv
`default_nettype none
// ============================================================================
// Module      : term_link
// Description : Design-side endpoint of the simulator byte link. Buffers user
//               bytes to the host (txclk strobes) and queues host bytes
//               acknowledged with rxclk strobes.
// Revision    : 1.0
// ============================================================================
module term_link #(
    parameter int DEPTH = 4
) (
    input  logic                    hz100,
    input  logic                    reset,
    input  logic                    txready,
    input  logic                    rxready,
    input  logic [7:0]              rxdata,
    output logic [7:0]              txdata,
    output logic                    txclk,
    output logic                    rxclk,
    input  logic [7:0]              in_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [7:0]              out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [$clog2(DEPTH):0]  tx_count,
    output logic [$clog2(DEPTH):0]  rx_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    typedef enum logic [1:0] {
        T_IDLE   = 2'd0,
        T_SETUP  = 2'd1,
        T_STROBE = 2'd2,
        T_WAIT   = 2'd3
    } tx_state_t;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_ACK  = 2'd1,
        R_WAIT = 2'd2
    } rx_state_t;

    tx_state_t      tx_state;
    rx_state_t      rx_state;
    logic           txr_meta, txr_s;
    logic           rxr_meta, rxr_s;
    logic [7:0]     tx_mem [DEPTH];
    logic [7:0]     rx_mem [DEPTH];
    logic [AW-1:0]  tx_wr, tx_rd, rx_wr, rx_rd;
    logic           tx_push, tx_pop, rx_push, rx_pop;

    // Handshake levels come from the host clock domain.
    always_ff @(posedge hz100) begin
        if (reset) begin
            txr_meta <= 1'b0;
            txr_s    <= 1'b0;
            rxr_meta <= 1'b0;
            rxr_s    <= 1'b0;
        end else begin
            txr_meta <= txready;
            txr_s    <= txr_meta;
            rxr_meta <= rxready;
            rxr_s    <= rxr_meta;
        end
    end

    assign in_ready  = (tx_count != CNT_FULL);
    assign tx_push   = in_valid & in_ready;
    assign tx_pop    = (tx_state == T_STROBE) && (tx_count != '0);
    assign txclk     = (tx_state == T_STROBE);

    // R_ACK is only entered with space available, so the push never overflows.
    assign rx_push   = (rx_state == R_ACK);
    assign rxclk     = (rx_state == R_ACK);
    assign out_valid = (rx_count != '0);
    assign rx_pop    = out_ready & out_valid;
    assign out_data  = rx_mem[rx_rd];

    always_ff @(posedge hz100) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) tx_mem[i] <= 8'h00;
            tx_wr    <= '0;
            tx_rd    <= '0;
            tx_count <= '0;
        end else begin
            if (tx_push) begin
                tx_mem[tx_wr] <= in_data;
                tx_wr         <= tx_wr + PTR_ONE;
            end
            if (tx_pop) tx_rd <= tx_rd + PTR_ONE;
            case ({tx_push, tx_pop})
                2'b10:   tx_count <= tx_count + CNT_ONE;
                2'b01:   tx_count <= tx_count - CNT_ONE;
                default: tx_count <= tx_count;
            endcase
        end
    end

    always_ff @(posedge hz100) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) rx_mem[i] <= 8'h00;
            rx_wr    <= '0;
            rx_rd    <= '0;
            rx_count <= '0;
        end else begin
            if (rx_push) begin
                rx_mem[rx_wr] <= rxdata;
                rx_wr         <= rx_wr + PTR_ONE;
            end
            if (rx_pop) rx_rd <= rx_rd + PTR_ONE;
            case ({rx_push, rx_pop})
                2'b10:   rx_count <= rx_count + CNT_ONE;
                2'b01:   rx_count <= rx_count - CNT_ONE;
                default: rx_count <= rx_count;
            endcase
        end
    end

    // One byte per txready high period: T_WAIT holds until the host drops it.
    always_ff @(posedge hz100) begin
        if (reset) begin
            tx_state <= T_IDLE;
            txdata   <= 8'h00;
        end else begin
            case (tx_state)
                T_IDLE: begin
                    if ((tx_count != '0) && txr_s) begin
                        txdata   <= tx_mem[tx_rd];
                        tx_state <= T_SETUP;
                    end
                end
                T_SETUP:  tx_state <= T_STROBE;
                T_STROBE: tx_state <= T_WAIT;
                T_WAIT:   if (!txr_s) tx_state <= T_IDLE;
                default:  tx_state <= T_IDLE;
            endcase
        end
    end

    always_ff @(posedge hz100) begin
        if (reset) begin
            rx_state <= R_IDLE;
        end else begin
            case (rx_state)
                R_IDLE:  if (rxr_s && (rx_count != CNT_FULL)) rx_state <= R_ACK;
                R_ACK:   rx_state <= R_WAIT;
                R_WAIT:  if (!rxr_s) rx_state <= R_IDLE;
                default: rx_state <= R_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_term_link.sv
`default_nettype none
// ============================================================================
// Module      : tb_term_link
// Description : Directed self-checking bench for term_link (DEPTH=4).
// Revision    : 1.0
// ============================================================================
module tb_term_link;
    logic       hz100     = 1'b0;
    logic       reset     = 1'b1;
    logic       txready   = 1'b0;
    logic       rxready   = 1'b0;
    logic [7:0] rxdata    = 8'h00;
    logic [7:0] in_data   = 8'h00;
    logic       in_valid  = 1'b0;
    logic       out_ready = 1'b0;
    logic [7:0] txdata;
    logic       txclk;
    logic       rxclk;
    logic       in_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic [2:0] tx_count;
    logic [2:0] rx_count;

    int n_cmp = 0;
    int n_bad = 0;

    term_link #(.DEPTH(4)) dut (
        .hz100     (hz100),
        .reset     (reset),
        .txready   (txready),
        .rxready   (rxready),
        .rxdata    (rxdata),
        .txdata    (txdata),
        .txclk     (txclk),
        .rxclk     (rxclk),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .tx_count  (tx_count),
        .rx_count  (rx_count)
    );

    always #5 hz100 = ~hz100;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge hz100);
        #1;
    endtask

    task automatic wait_txclk(input int limit, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < limit; i++) begin
            tick();
            if (txclk === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_rxclk(input int limit, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < limit; i++) begin
            tick();
            if (rxclk === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b1; in_data = 8'h77;
        rxready = 1'b1; rxdata = 8'h11; txready = 1'b1; out_ready = 1'b1;
        tick();
        n_cmp++; if (tx_count !== 3'd0) begin n_bad++; $display("FAIL reset_tx_count_1: got %0d required 0", tx_count); end
        tick();
        n_cmp++; if (tx_count !== 3'd0) begin n_bad++; $display("FAIL reset_tx_count_2: got %0d required 0", tx_count); end
        n_cmp++; if ({txclk, rxclk, in_ready, out_valid} !== 4'b0010) begin n_bad++; $display("FAIL reset_flags: got txclk/rxclk/in_ready/out_valid=%b required 0010", {txclk, rxclk, in_ready, out_valid}); end
        n_cmp++; if (txdata !== 8'h00 || out_data !== 8'h00) begin n_bad++; $display("FAIL reset_data: got txdata=%h out_data=%h required 00 00", txdata, out_data); end
        n_cmp++; if (rx_count !== 3'd0) begin n_bad++; $display("FAIL reset_rx_count: got %0d required 0", rx_count); end
        reset = 1'b0; in_valid = 1'b0; rxready = 1'b0; txready = 1'b0; out_ready = 1'b0;
        repeat (4) tick();
        n_cmp++; if (tx_count !== 3'd0 || rx_count !== 3'd0 || txclk !== 1'b0 || rxclk !== 1'b0) begin n_bad++; $display("FAIL reset_release_idle: got tx=%0d rx=%0d txclk=%b rxclk=%b required 0 0 0 0", tx_count, rx_count, txclk, rxclk); end
    endtask

    task automatic test_tx_single();
        bit seen;
        txready = 1'b1;
        repeat (3) tick();
        in_data = 8'hA5; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        n_cmp++; if (tx_count !== 3'd1 || txclk !== 1'b0) begin n_bad++; $display("FAIL tx_push: got count=%0d txclk=%b required 1 0", tx_count, txclk); end
        tick();
        n_cmp++; if (txdata !== 8'hA5 || txclk !== 1'b0) begin n_bad++; $display("FAIL tx_setup: got txdata=%h txclk=%b required a5 0", txdata, txclk); end
        tick();
        n_cmp++; if (txclk !== 1'b1 || txdata !== 8'hA5) begin n_bad++; $display("FAIL tx_strobe: got txclk=%b txdata=%h required 1 a5", txclk, txdata); end
        tick();
        n_cmp++; if (txclk !== 1'b0 || tx_count !== 3'd0) begin n_bad++; $display("FAIL tx_after_strobe: got txclk=%b count=%0d required 0 0", txclk, tx_count); end
        in_data = 8'h3C; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        seen = 1'b0;
        repeat (6) begin
            tick();
            if (txclk === 1'b1) seen = 1'b1;
        end
        n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL tx_one_per_ready: got second strobe=%b required 0", seen); end
        n_cmp++; if (tx_count !== 3'd1 || txdata !== 8'hA5) begin n_bad++; $display("FAIL tx_hold: got count=%0d txdata=%h required 1 a5", tx_count, txdata); end
        txready = 1'b0;
        repeat (4) tick();
        txready = 1'b1;
        wait_txclk(10, seen);
        n_cmp++; if (seen !== 1'b1 || txdata !== 8'h3C) begin n_bad++; $display("FAIL tx_second: got strobe=%b txdata=%h required 1 3c", seen, txdata); end
        tick();
        n_cmp++; if (tx_count !== 3'd0) begin n_bad++; $display("FAIL tx_second_count: got %0d required 0", tx_count); end
        txready = 1'b0;
        repeat (4) tick();
    endtask

    task automatic test_tx_full();
        bit seen;
        for (int i = 1; i <= 5; i++) begin
            in_data = 8'(i); in_valid = 1'b1;
            n_cmp++; if (in_ready !== ((i <= 4) ? 1'b1 : 1'b0)) begin n_bad++; $display("FAIL tx_full_in_ready_%0d: got %b required %b", i, in_ready, (i <= 4)); end
            tick();
        end
        in_valid = 1'b0;
        n_cmp++; if (tx_count !== 3'd4) begin n_bad++; $display("FAIL tx_full_count: got %0d required 4", tx_count); end
        for (int k = 1; k <= 4; k++) begin
            txready = 1'b1;
            wait_txclk(10, seen);
            n_cmp++; if (seen !== 1'b1 || txdata !== 8'(k)) begin n_bad++; $display("FAIL tx_full_order_%0d: got strobe=%b txdata=%h required 1 %h", k, seen, txdata, 8'(k)); end
            txready = 1'b0;
            repeat (5) tick();
        end
        n_cmp++; if (tx_count !== 3'd0) begin n_bad++; $display("FAIL tx_full_drain: got %0d required 0", tx_count); end
        txready = 1'b1;
        seen = 1'b0;
        repeat (8) begin
            tick();
            if (txclk === 1'b1) seen = 1'b1;
        end
        n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL tx_full_refused: got strobe=%b required 0", seen); end
        txready = 1'b0;
        repeat (4) tick();
    endtask

    task automatic test_rx_single();
        rxdata = 8'h5A; rxready = 1'b1;
        tick();
        tick();
        n_cmp++; if (rxclk !== 1'b0) begin n_bad++; $display("FAIL rx_early: got rxclk=%b required 0", rxclk); end
        tick();
        n_cmp++; if (rxclk !== 1'b1 || out_valid !== 1'b0) begin n_bad++; $display("FAIL rx_ack: got rxclk=%b out_valid=%b required 1 0", rxclk, out_valid); end
        tick();
        n_cmp++; if (rxclk !== 1'b0 || out_valid !== 1'b1 || out_data !== 8'h5A || rx_count !== 3'd1) begin n_bad++; $display("FAIL rx_queued: got rxclk=%b valid=%b data=%h count=%0d required 0 1 5a 1", rxclk, out_valid, out_data, rx_count); end
        rxready = 1'b0; out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        n_cmp++; if (out_valid !== 1'b0 || rx_count !== 3'd0) begin n_bad++; $display("FAIL rx_pop: got valid=%b count=%0d required 0 0", out_valid, rx_count); end
        repeat (4) tick();
    endtask

    task automatic test_rx_backpressure();
        bit seen;
        for (int b = 0; b < 5; b++) begin
            rxdata = 8'h10 + 8'(b); rxready = 1'b1;
            wait_rxclk(8, seen);
            n_cmp++; if (seen !== ((b < 4) ? 1'b1 : 1'b0)) begin n_bad++; $display("FAIL rx_bp_ack_%0d: got rxclk seen=%b required %b", b, seen, (b < 4)); end
            if (b < 4) begin
                rxready = 1'b0;
                repeat (4) tick();
            end
        end
        n_cmp++; if (rx_count !== 3'd4 || out_data !== 8'h10) begin n_bad++; $display("FAIL rx_bp_full: got count=%0d head=%h required 4 10", rx_count, out_data); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        wait_rxclk(8, seen);
        n_cmp++; if (seen !== 1'b1) begin n_bad++; $display("FAIL rx_bp_resume: got rxclk seen=%b required 1", seen); end
        rxready = 1'b0;
        repeat (4) tick();
        n_cmp++; if (rx_count !== 3'd4) begin n_bad++; $display("FAIL rx_bp_refill: got count=%0d required 4", rx_count); end
        for (int j = 0; j < 4; j++) begin
            n_cmp++; if (out_valid !== 1'b1 || out_data !== 8'h11 + 8'(j)) begin n_bad++; $display("FAIL rx_bp_order_%0d: got valid=%b data=%h required 1 %h", j, out_valid, out_data, 8'h11 + 8'(j)); end
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
        end
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rx_bp_empty: got valid=%b required 0", out_valid); end
    endtask

    task automatic test_concurrency();
        bit seen;
        in_data = 8'hAA; in_valid = 1'b1;
        tick();
        in_data = 8'hBB;
        tick();
        in_valid = 1'b0;
        n_cmp++; if (tx_count !== 3'd2) begin n_bad++; $display("FAIL conc_fill: got count=%0d required 2", tx_count); end
        rxdata = 8'hC3; txready = 1'b1; rxready = 1'b1;
        repeat (3) tick();
        n_cmp++; if (rxclk !== 1'b1 || txclk !== 1'b0 || txdata !== 8'hAA) begin n_bad++; $display("FAIL conc_rx_ack: got rxclk=%b txclk=%b txdata=%h required 1 0 aa", rxclk, txclk, txdata); end
        tick();
        n_cmp++; if (txclk !== 1'b1 || tx_count !== 3'd2 || rx_count !== 3'd1) begin n_bad++; $display("FAIL conc_tx_strobe: got txclk=%b tx=%0d rx=%0d required 1 2 1", txclk, tx_count, rx_count); end
        in_data = 8'hCC; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        n_cmp++; if (tx_count !== 3'd2 || txclk !== 1'b0 || out_data !== 8'hC3) begin n_bad++; $display("FAIL conc_push_pop: got tx=%0d txclk=%b out_data=%h required 2 0 c3", tx_count, txclk, out_data); end
        rxready = 1'b0; reset = 1'b1;
        tick();
        reset = 1'b0;
        n_cmp++; if (tx_count !== 3'd0 || rx_count !== 3'd0 || in_ready !== 1'b1 || out_valid !== 1'b0 || txclk !== 1'b0 || txdata !== 8'h00) begin n_bad++; $display("FAIL conc_reset: got tx=%0d rx=%0d rdy=%b val=%b txclk=%b txdata=%h required 0 0 1 0 0 00", tx_count, rx_count, in_ready, out_valid, txclk, txdata); end
        in_data = 8'hDD; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        wait_txclk(10, seen);
        n_cmp++; if (seen !== 1'b1 || txdata !== 8'hDD) begin n_bad++; $display("FAIL conc_after_reset: got strobe=%b txdata=%h required 1 dd", seen, txdata); end
        txready = 1'b0;
        repeat (4) tick();
    endtask

    initial begin
        test_reset();
        test_tx_single();
        test_tx_full();
        test_rx_single();
        test_rx_backpressure();
        test_concurrency();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
